serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around one `full_adder_1bit` instance and a carry flip-flop. It accepts a pair of operands plus carry-in on a start strobe and presents one operand bit pair per clock, LSB first, to the full adder. It returns the registered sum and carry-out with a one-cycle done pulse. It is the sequential consumer stage that drives `full_adder_1bit`, and it trades WIDTH+1 cycles of latency for a single-bit datapath.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and counter sizing.
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

    // Counter must hold 0..WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module full_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first,
// through a single full adder and a carry flip-flop.
//
// state  | meaning
// IDLE   | waiting for start_i, result registers hold last value
// RUN    | shifting one bit pair per cycle through the full adder
// DONE   | result valid, one-cycle done pulse; start_i reloads back-to-back
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;
    logic             w_unused_s_lsb;

    full_adder_1bit u_fa (
        .a_i    (r_a_sr[0]),
        .b_i    (r_b_sr[0]),
        .cin_i  (r_carry),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    assign w_accept = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_s_next = {w_sum, r_s_sr[WIDTH-1:1]};
    // The LSB of the sum shifter is shifted out and never read.
    assign w_unused_s_lsb = r_s_sr[0];

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start_i) w_next_state = S_RUN;
            S_RUN:   if (w_last)  w_next_state = S_DONE;
            S_DONE:  w_next_state = start_i ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a_sr  <= a_i;
                r_b_sr  <= b_i;
                r_carry <= cin_i;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sr  <= r_a_sr >> 1;
                r_b_sr  <= r_b_sr >> 1;
                r_s_sr  <= w_s_next;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum  <= w_s_next;
                    r_cout <= w_cout;
                end
            end
        end
    end

    assign busy_o = (r_state == S_RUN);
    assign done_o = (r_state == S_DONE);
    assign sum_o  = r_sum;
    assign cout_o = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       cin3 = 1'b0;
    logic       busy3, done3, cout3;
    logic [2:0] sum3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .a_i(a3), .b_i(b3), .cin_i(cin3),
        .busy_o(busy3), .done_o(done3), .sum_o(sum3), .cout_o(cout3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one 8-bit operation; inj > 0 fires an ignored start with 0x33+0x44
    // after that many cycles. Returns with the DUT in its DONE cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int inj, input string tag);
        logic [8:0] exp_res, prev;
        int n, nbusy;
        bit held_ok, overlap;
        exp_res = 9'(a) + 9'(b) + 9'(c);
        prev    = {cout8, sum8};
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        n = 0; nbusy = 0; held_ok = 1; overlap = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 1) start8 = 1'b0;
            if (inj > 0 && n == inj) begin
                start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
            end
            if (inj > 0 && n == inj + 1) start8 = 1'b0;
            if (busy8 && done8) overlap = 1;
            if (done8) break;
            if (busy8) nbusy++;
            if ({cout8, sum8} !== prev) held_ok = 0;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_busy_cycles"}, nbusy, 8);
        chk({tag, "_hold_prev"}, 32'(held_ok), 1);
        chk({tag, "_overlap"}, 32'(overlap), 0);
        chk({tag, "_result"}, 32'({cout8, sum8}), 32'(exp_res));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [3:0] exp3;
        int         n;
        bit         extra_done;

        repeat (3) tick();
        chk("reset_busy", 32'(busy8), 0);
        chk("reset_done", 32'(done8), 0);
        chk("reset_out", 32'({cout8, sum8}), 0);
        rst = 1'b0;
        tick();

        op8(8'h0F, 8'h01, 1'b0, 0, "basic");
        tick();
        chk("basic_done_pulse_width", 32'(done8), 0);

        op8(8'hFF, 8'h01, 1'b0, 0, "ripple1");
        tick();
        op8(8'hFF, 8'h00, 1'b1, 0, "ripple2");
        tick();
        op8(8'hA5, 8'h5A, 1'b1, 0, "ripple3");
        tick();

        op8(8'h20, 8'h07, 1'b1, 3, "ignored");
        extra_done = 0;
        repeat (14) begin
            tick();
            if (done8 || busy8) extra_done = 1;
        end
        chk("ignored_no_extra_done", 32'(extra_done), 0);
        chk("ignored_result_held", 32'({cout8, sum8}), 32'h028);

        op8(8'h81, 8'h80, 1'b0, 0, "b2b_first");
        op8(8'h12, 8'h34, 1'b0, 0, "b2b_second");
        tick();

        a8 = 8'h77; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy8), 0);
        chk("midrst_done", 32'(done8), 0);
        chk("midrst_out", 32'({cout8, sum8}), 0);
        extra_done = 0;
        repeat (12) begin
            tick();
            if (done8 || busy8) extra_done = 1;
        end
        chk("midrst_no_done", 32'(extra_done), 0);
        op8(8'h01, 8'h01, 1'b0, 0, "after_rst");
        tick();

        a8 = 8'h10; b8 = 8'h10; start8 = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start8 = 1'b0;
        chk("rst_vs_start_busy", 32'(busy8), 0);
        chk("rst_vs_start_out", 32'({cout8, sum8}), 0);
        tick();
        chk("rst_vs_start_idle", 32'(busy8), 0);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            op8(ra, rb, rc, 0, "rand_b2b");
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();

        for (int v = 0; v < 128; v++) begin
            a3 = 3'(v >> 4); b3 = 3'(v >> 1); cin3 = 1'(v);
            exp3 = 4'(a3) + 4'(b3) + 4'(cin3);
            start3 = 1'b1;
            n = 0;
            while (n < 20) begin
                tick();
                n++;
                if (n == 1) start3 = 1'b0;
                if (done3) break;
            end
            if (v == 0 || v == 127) chk("w3_latency", n, 4);
            chk("w3_result", 32'({cout3, sum3}), 32'(exp3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
